// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, coordinate widths and total helper
package vga_pkg;

    localparam int XW = 11;
    localparam int YW = 10;

    // 640x480@60 industry timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int frame_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled WIDTH x DEPTH shift register with async active-low clear
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en};
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_text_timing.sv
// rtl/vga_text_timing.sv - VGA raster and text-cell timing generator (VGA_TEST_PATTERN_EN adds pattern_rgb)
module vga_text_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter int   CLK_DIV    = 2,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   CHAR_W     = 8,
    parameter int   CHAR_H     = 16,
    parameter int   SYNC_DELAY = 2,
    localparam int  GXW        = (CHAR_W > 1) ? $clog2(CHAR_W) : 1,
    localparam int  GYW        = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
    input  logic           CLOCK_50,
    input  logic           RESET,
    output logic           pix_en,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic           active,
    output logic [6:0]     char_col,
    output logic [5:0]     char_row,
    output logic [GXW-1:0] glyph_x,
    output logic [GYW-1:0] glyph_y,
    output logic           frame_start,
    output logic           active_d,
    output logic           VGA_HSYNC,
    output logic           VGA_VSYNC
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [2:0]     pattern_rgb
`endif
);

    localparam int H_TOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0]  X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]  X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0]  X_ACT_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0]  HS_ON      = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]  HS_OFF     = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0]  Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]  Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0]  Y_ACT_LAST = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0]  VS_ON      = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]  VS_OFF     = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [GXW-1:0] GX_LAST    = GXW'(CHAR_W - 1);
    localparam logic [GYW-1:0] GY_LAST    = GYW'(CHAR_H - 1);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || CHAR_W < 1 || CHAR_H < 1 ||
        SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_params
        $error("vga_text_timing: illegal timing parameters");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_n;
    logic          pix_en_n;
    logic          x_wrap;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic          hs_q;
    logic          vs_q;

    always_comb begin
        div_n    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_n = (div_n == DIV_LAST);
        x_wrap   = (x == X_LAST);
        x_n      = x;
        y_n      = y;
        if (pix_en) begin
            x_n = x_wrap ? '0 : x + 1'b1;
            if (x_wrap) y_n = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    // Flags are computed from the next coordinates so they change in the same cycle as x/y.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            div_q       <= '0;
            pix_en      <= 1'b0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_n;
            pix_en      <= pix_en_n;
            x           <= x_n;
            y           <= y_n;
            active      <= (x_n < X_ACT) && (y_n < Y_ACT);
            hs_q        <= (x_n >= HS_ON) && (x_n < HS_OFF);
            vs_q        <= (y_n >= VS_ON) && (y_n < VS_OFF);
            frame_start <= pix_en_n && (x_n == '0) && (y_n == '0);
        end
    end

    // Cell counters track the next pixel; the last active pixel/line clears them for blanking.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            glyph_x  <= '0;
            char_col <= '0;
            glyph_y  <= '0;
            char_row <= '0;
        end else if (pix_en) begin
            if (x >= X_ACT_LAST) begin
                glyph_x  <= '0;
                char_col <= '0;
            end else if (glyph_x == GX_LAST) begin
                glyph_x  <= '0;
                char_col <= char_col + 1'b1;
            end else begin
                glyph_x  <= glyph_x + 1'b1;
            end

            if (x_wrap) begin
                if (y >= Y_ACT_LAST) begin
                    glyph_y  <= '0;
                    char_row <= '0;
                end else if (glyph_y == GY_LAST) begin
                    glyph_y  <= '0;
                    char_row <= char_row + 1'b1;
                end else begin
                    glyph_y  <= glyph_y + 1'b1;
                end
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int DLW = 6;
    logic [2:0] rgb_raw;
    assign rgb_raw = active ? (char_col[2:0] ^ {3{char_row[0]}}) : 3'b000;
`else
    localparam int DLW = 3;
`endif

    logic [DLW-1:0] dl_in;
    logic [DLW-1:0] dl_out;

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in       = {hs_q, vs_q, active, rgb_raw};
    assign pattern_rgb = dl_out[2:0];
`else
    assign dl_in       = {hs_q, vs_q, active};
`endif

    vga_delay_line #(
        .WIDTH (DLW),
        .DEPTH (SYNC_DELAY)
    ) u_delay (
        .clk   (CLOCK_50),
        .rst_n (RESET),
        .en    (pix_en),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign VGA_HSYNC = dl_out[DLW-1] ? HSYNC_POL : ~HSYNC_POL;
    assign VGA_VSYNC = dl_out[DLW-2] ? VSYNC_POL : ~VSYNC_POL;
    assign active_d  = dl_out[DLW-3];

endmodule

// File: tb/tb_vga_text_timing.sv
// tb/tb_vga_text_timing.sv - directed scoreboard bench for vga_text_timing (default and alternate configs)
module tb_vga_text_timing;

    localparam int A_V_TOTAL   = 20 + 3 + 2 + 2;
    localparam int A_FRAME_CYC = 800 * A_V_TOTAL * 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_pix_en, a_active, a_fs, a_active_d, a_hs, a_vs;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic [6:0]  a_col;
    logic [5:0]  a_row;
    logic [2:0]  a_gx;
    logic [3:0]  a_gy;
    logic        b_pix_en, b_active, b_fs, b_active_d, b_hs, b_vs;
    logic [10:0] b_x;
    logic [9:0]  b_y;
    logic [6:0]  b_col;
    logic [5:0]  b_row;
    logic [2:0]  b_gx;
    logic [3:0]  b_gy;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  a_rgb, b_rgb;
`endif

    vga_text_timing #(
        .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(2)
    ) dut_a (
        .CLOCK_50(clk), .RESET(rst_a), .pix_en(a_pix_en), .x(a_x), .y(a_y), .active(a_active),
        .char_col(a_col), .char_row(a_row), .glyph_x(a_gx), .glyph_y(a_gy), .frame_start(a_fs),
        .active_d(a_active_d), .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs)
`ifdef VGA_TEST_PATTERN_EN
        , .pattern_rgb(a_rgb)
`endif
    );

    vga_text_timing #(
        .H_ACTIVE(640), .CLK_DIV(1), .HSYNC_POL(1'b1), .SYNC_DELAY(0), .CHAR_W(6),
        .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .CLOCK_50(clk), .RESET(rst_b), .pix_en(b_pix_en), .x(b_x), .y(b_y), .active(b_active),
        .char_col(b_col), .char_row(b_row), .glyph_x(b_gx), .glyph_y(b_gy), .frame_start(b_fs),
        .active_d(b_active_d), .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs)
`ifdef VGA_TEST_PATTERN_EN
        , .pattern_rgb(b_rgb)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic observe(input bit valid, input logic [31:0] obs);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard: observed %0d with no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            if (!valid) begin
                fails++;
                $error("FAIL %s: observed timeout, expected %0d", e.tag, e.value);
            end else begin
                assert (obs === e.value) else begin
                    fails++;
                    $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.value);
                end
            end
        end
    endtask

    int hs_first, hs_last, hs_cnt, bad, n, prev_x, vs_cnt, cyc_fs0;
    bit ok;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        expect_val("rst_a_pix_en", 0);      observe(1'b1, a_pix_en);
        expect_val("rst_a_x", 0);           observe(1'b1, a_x);
        expect_val("rst_a_y", 0);           observe(1'b1, a_y);
        expect_val("rst_a_frame_start", 0); observe(1'b1, a_fs);
        expect_val("rst_a_active_d", 0);    observe(1'b1, a_active_d);
        expect_val("rst_a_hsync", 1);       observe(1'b1, a_hs);
        expect_val("rst_a_vsync", 1);       observe(1'b1, a_vs);
        expect_val("rst_a_char_col", 0);    observe(1'b1, a_col);
        expect_val("rst_b_pix_en", 0);      observe(1'b1, b_pix_en);
        expect_val("rst_b_hsync", 0);       observe(1'b1, b_hs);

        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_val("a_pix_en_pattern", (k % 2 == 0) ? 1 : 0);
            expect_val("a_x_early", (k + 1) / 2);
            expect_val("b_pix_en_pattern", 1);
            expect_val("b_x_early", k);
            @(negedge clk);
            if (k == 0) cyc_fs0 = cyc;
            observe(1'b1, a_pix_en);
            observe(1'b1, a_x);
            observe(1'b1, b_pix_en);
            observe(1'b1, b_x);
            if (k < 2) begin
                expect_val("a_frame_start_early", (k == 0) ? 1 : 0);
                expect_val("b_frame_start_early", (k == 0) ? 1 : 0);
                observe(1'b1, a_fs);
                observe(1'b1, b_fs);
            end
        end

        // alternate config: walk the first line of dut_b
        expect_val("b_col_635", 105);  expect_val("b_gx_635", 5);
        expect_val("b_col_636", 106);  expect_val("b_gx_636", 0);
        expect_val("b_col_639", 106);  expect_val("b_gx_639", 3);
        expect_val("b_col_640", 0);    expect_val("b_gx_640", 0);  expect_val("b_active_640", 0);
        expect_val("b_pix_en_gaps", 0);
        expect_val("b_hs_first_x", 656);
        expect_val("b_hs_last_x", 751);
        expect_val("b_hs_count", 96);
        hs_first = -1; hs_last = -1; hs_cnt = 0; bad = 0; n = 0;
        while (b_x != 11'd799 && n < 3000) begin
            @(negedge clk);
            n++;
            if (b_pix_en !== 1'b1) bad++;
            if (b_hs === 1'b1) begin
                if (hs_first < 0) hs_first = int'(b_x);
                hs_last = int'(b_x);
                hs_cnt++;
            end
            case (b_x)
                11'd635, 11'd636: begin observe(1'b1, b_col); observe(1'b1, b_gx); end
                11'd639: begin observe(1'b1, b_col); observe(1'b1, b_gx); end
                11'd640: begin observe(1'b1, b_col); observe(1'b1, b_gx); observe(1'b1, b_active); end
                default: ;
            endcase
        end
        ok = (n < 3000);
        observe(ok, bad);
        observe(ok, hs_first);
        observe(ok, hs_last);
        observe(ok, hs_cnt);

        // default config: hsync window and line wrap of dut_a
        expect_val("a_hs_first_x", 658);
        expect_val("a_hs_pix_count", 96);
        expect_val("a_x_before_wrap", 799);
        expect_val("a_x_after_wrap", 0);
        hs_first = -1; hs_cnt = 0; prev_x = -1; n = 0;
        while (a_y == 10'd0 && n < 5000) begin
            @(negedge clk);
            n++;
            if (a_y == 10'd0) prev_x = int'(a_x);
            if (a_hs === 1'b0) begin
                if (hs_first < 0) hs_first = int'(a_x);
                if (a_pix_en === 1'b1) hs_cnt++;
            end
        end
        ok = (n < 5000);
        observe(ok, hs_first);
        observe(ok, hs_cnt);
        observe(ok, prev_x);
        observe(ok, a_x);

        // last active pixel of the last active line, then the first blank pixel
        expect_val("a_col_639_19", 79);  expect_val("a_gx_639_19", 7);
        expect_val("a_row_639_19", 1);   expect_val("a_gy_639_19", 3);
        expect_val("a_active_639_19", 1);
        n = 0;
        while (!(a_x == 11'd639 && a_y == 10'd19) && n < 40000) begin @(negedge clk); n++; end
        ok = (n < 40000);
        observe(ok, a_col); observe(ok, a_gx); observe(ok, a_row); observe(ok, a_gy); observe(ok, a_active);
        expect_val("a_col_640", 0); expect_val("a_gx_640", 0); expect_val("a_active_640", 0);
        n = 0;
        while (a_x != 11'd640 && n < 10) begin @(negedge clk); n++; end
        ok = (n < 10);
        observe(ok, a_col); observe(ok, a_gx); observe(ok, a_active);

        // vsync: two lines starting at V_ACTIVE+V_FP, delayed two pixels
        expect_val("a_vs_first_y", 23);
        expect_val("a_vs_first_x", 2);
        expect_val("a_vs_pix_count", 1600);
        n = 0;
        while (a_vs !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        ok = (n < 20000);
        observe(ok, a_y);
        observe(ok, a_x);
        vs_cnt = 0; n = 0;
        while (a_vs === 1'b0 && n < 5000) begin
            if (a_pix_en === 1'b1) vs_cnt++;
            @(negedge clk);
            n++;
        end
        observe(ok && n < 5000, vs_cnt);

        // frame_start recurrence
        expect_val("a_frame_period_cycles", A_FRAME_CYC);
        n = 0;
        while (a_fs !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        observe(n < 10000, cyc - cyc_fs0);

        // mid-frame reset
        expect_val("mid_rst_x", 0);        expect_val("mid_rst_y", 0);
        expect_val("mid_rst_hsync", 1);    expect_val("mid_rst_vsync", 1);
        expect_val("mid_rst_pix_en", 0);   expect_val("mid_rst_active_d", 0);
        expect_val("mid_rst_active", 0);   expect_val("mid_rst_char_col", 0);
        expect_val("mid_rst_frame_start", 0);
        n = 0;
        while (!(a_x == 11'd300 && a_y == 10'd2) && n < 10000) begin @(negedge clk); n++; end
        ok = (n < 10000);
        rst_a = 1'b0;
        #1;
        observe(ok, a_x);        observe(ok, a_y);
        observe(ok, a_hs);       observe(ok, a_vs);
        observe(ok, a_pix_en);   observe(ok, a_active_d);
        observe(ok, a_active);   observe(ok, a_col);
        observe(ok, a_fs);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        expect_val("post_rst_frame_start", 1); expect_val("post_rst_pix_en", 1);
        expect_val("post_rst_x", 0);           expect_val("post_rst_y", 0);
        @(negedge clk);
        observe(1'b1, a_fs); observe(1'b1, a_pix_en); observe(1'b1, a_x); observe(1'b1, a_y);
        expect_val("post_rst_frame_start_next", 0); expect_val("post_rst_x_next", 1);
        @(negedge clk);
        observe(1'b1, a_fs); observe(1'b1, a_x);

        while (exp_q.size() > 0) observe(1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
